instr_prefetch: RTL
===================

INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the buffer entry count; legal values are powers of two from 2 to 16.
REQ-002 Parameter RESET_PC, default 16'h0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 redirect  input  1  flush the buffer and restart fetch at redirect_pc.
REQ-006 redirect_pc  input  16  new fetch PC, sampled when redirect=1.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  12  instruction-memory word address, equal to fetch_pc[11:0].
REQ-009 imem_data  input  16  read data, valid exactly one cycle after the cycle in which imem_req=1.
REQ-010 out_valid  output  1  the buffer head holds an instruction.
REQ-011 out_ready  input  1  the IF stage accepts the head.
REQ-012 out_instr  output  16  head instruction.
REQ-013 out_pc  output  16  PC of the head instruction.

Function
REQ-014 The block SHALL keep a 16-bit fetch_pc, a FIFO of DEPTH {pc,instr} entries, a count register, and a 1-bit inflight flag with the 16-bit PC of the outstanding request.
REQ-015 imem_req SHALL be 1 when redirect=0 and count + inflight - pop < DEPTH, where pop = out_valid & out_ready.
REQ-016 When imem_req=1, the block SHALL set inflight=1, latch fetch_pc as the inflight PC, and increment fetch_pc by 1 (mod 2^16).
REQ-017 In the cycle after a request, the block SHALL push {inflight PC, imem_data} into the FIFO unless that request was cancelled by redirect.
REQ-018 out_valid SHALL equal (count != 0) & ~redirect; out_instr and out_pc SHALL show the head entry.
REQ-019 A push and a pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-020 Full boundary: a push SHALL never happen when count = DEPTH without a pop; REQ-015 guarantees this.
REQ-021 Empty boundary: a response never bypasses the FIFO; it becomes visible on out_valid one cycle after the push edge.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 On redirect=1, at the next edge the block SHALL:
  - clear count and the pointers;
  - discard any response arriving in the following cycle;
  - set fetch_pc = redirect_pc.
REQ-024 During a redirect cycle imem_req=0 and no pop occurs, even if out_ready=1.
REQ-025 The first request at redirect_pc SHALL be issued in the cycle after redirect.
REQ-026 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-027 Steady state with out_ready=1 held SHALL deliver one instruction per cycle; latency from request to out_valid is 2 cycles.

Reset
REQ-028 While rst_n=0, asynchronously, the block SHALL hold:
  - count = 0, pointers = 0, inflight = 0;
  - fetch_pc = RESET_PC;
  - out_valid = 0, imem_req = 0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered and in-flight data.
REQ-030 The first request SHALL issue in the first cycle after rst_n rises, with imem_addr = RESET_PC[11:0].

Configuration
REQ-031 With macro PREFETCH_STATS_EN defined, the block SHALL add two outputs, stat_fetches (16) and stat_flushes (16):
  - stat_fetches counts cycles with imem_req=1;
  - stat_flushes counts cycles with redirect=1;
  - both counters saturate at 16'hFFFF and reset to 0.
REQ-032 Without PREFETCH_STATS_EN, those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-033 Release reset with out_ready=1 and memory returning mem[a] = a ^ 16'hA5A5 -> imem_addr = 0,1,2,... every cycle; out_pc = 0 appears 2 cycles after reset release, followed by 1,2,3 on consecutive cycles with matching data.
REQ-034 Hold out_ready=0 with DEPTH=4 -> exactly 4 requests (addresses 0..3), count = 4, imem_req stays 0; set out_ready=1 -> entries 0..3 drain in order while fetching resumes at address 4.
REQ-035 Assert redirect with redirect_pc = 16'h0100 while 3 entries are buffered and a request is in flight -> next cycle out_valid = 0; the stale response is dropped; the next imem_addr = 12'h100; out_pc = 16'h0100 arrives 2 cycles after that request.
REQ-036 Assert redirect in consecutive cycles to 16'h0010 then 16'h0020 -> only address 12'h020 is fetched, and no entry with PC 16'h0010 is ever output.
REQ-037 Set fetch_pc near the top, then run -> PC sequence 16'hFFFF, 16'h0000, with imem_addr wrapping 12'hFFF to 12'h000.
REQ-038 Pull rst_n low mid-stream with 2 entries buffered -> out_valid = 0 immediately; after release, fetch restarts at RESET_PC; with PREFETCH_STATS_EN, stat_fetches counts from 0.

Source files
------------

// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer.
// Streams sequential fetch requests into a DEPTH-entry {pc, instr} FIFO.
// Instruction memory returns data one cycle after each request.
// A redirect flushes the FIFO, drops any response still outstanding and restarts
// fetching at the new PC.
// Optional build macro PREFETCH_STATS_EN adds two saturating 16-bit counters:
// stat_fetches counts request cycles and stat_flushes counts redirect cycles.
`timescale 1ns/1ps
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [11:0] o_imem_addr,
  input  logic [15:0] i_imem_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [15:0] o_out_instr,
  output logic [15:0] o_out_pc
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0] o_stat_fetches,
  output logic [15:0] o_stat_flushes
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

  // Architectural state
  logic [15:0]     r_fetch_pc;
  logic            r_inflight;
  logic [15:0]     r_inflight_pc;
  logic [CntW-1:0] r_count;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [15:0]     r_mem_pc    [DEPTH];
  logic [15:0]     r_mem_instr [DEPTH];

  // Next-state and control wires
  logic [15:0]     w_fetch_pc_nxt;
  logic            w_inflight_nxt;
  logic [15:0]     w_inflight_pc_nxt;
  logic [CntW-1:0] w_count_nxt;
  logic [PtrW-1:0] w_rd_ptr_nxt;
  logic [PtrW-1:0] w_wr_ptr_nxt;
  logic            w_pop;
  logic            w_push;
  logic            w_req;
  logic            w_out_valid;
  logic [CntW:0]   w_occupancy;

  // Handshake decode: occupancy counts the slot reserved by the outstanding request
  always_comb begin
    w_out_valid = (r_count != '0) & ~i_redirect;
    w_pop       = w_out_valid & i_out_ready;
    // A response landing in a redirect cycle belongs to the old stream
    w_push      = r_inflight & ~i_redirect;
    w_occupancy = {1'b0, r_count} + (CntW + 1)'(r_inflight) - (CntW + 1)'(w_pop);
    // rst_n gating keeps the request low while reset is held
    w_req       = rst_n & ~i_redirect & (w_occupancy < DepthW);
  end

  // Next-state for fetch PC, in-flight tracking, count and pointers
  always_comb begin
    w_fetch_pc_nxt    = r_fetch_pc;
    w_inflight_nxt    = w_req;
    w_inflight_pc_nxt = r_inflight_pc;
    w_count_nxt       = r_count;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_wr_ptr_nxt      = r_wr_ptr;
    if (i_redirect) begin
      w_fetch_pc_nxt = i_redirect_pc;
      w_inflight_nxt = 1'b0;
      w_count_nxt    = '0;
      w_rd_ptr_nxt   = '0;
      w_wr_ptr_nxt   = '0;
    end else begin
      if (w_req) begin
        w_fetch_pc_nxt    = r_fetch_pc + 16'd1;
        w_inflight_pc_nxt = r_fetch_pc;
      end
      // Pointers are PtrW wide, so they wrap modulo DEPTH on their own
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PtrW'(1);
      end
      w_count_nxt = r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_inflight    <= w_inflight_nxt;
      r_inflight_pc <= w_inflight_pc_nxt;
      r_count       <= w_count_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
    end
  end

  // FIFO storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
      r_mem_instr[r_wr_ptr] <= i_imem_data;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [15:0] r_stat_fetches;
  logic [15:0] r_stat_flushes;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_fetches <= 16'h0000;
      r_stat_flushes <= 16'h0000;
    end else begin
      if (w_req && (r_stat_fetches != 16'hFFFF)) begin
        r_stat_fetches <= r_stat_fetches + 16'd1;
      end
      if (i_redirect && (r_stat_flushes != 16'hFFFF)) begin
        r_stat_flushes <= r_stat_flushes + 16'd1;
      end
    end
  end

  assign o_stat_fetches = r_stat_fetches;
  assign o_stat_flushes = r_stat_flushes;
`endif

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_fetch_pc[11:0];
  assign o_out_valid = w_out_valid;
  assign o_out_pc    = r_mem_pc[r_rd_ptr];
  assign o_out_instr = r_mem_instr[r_rd_ptr];

endmodule
